// File: rtl/cva6_axi_mem_pkg.sv
// Shared AXI encodings and channel FSM state types for the scratchpad responder.
package cva6_axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/cva6_axi_mem_beat_ctr.sv
// Per-channel burst tracker: latched word index, beat count and burst type.
module cva6_axi_mem_beat_ctr
  import cva6_axi_mem_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_load,
  input  logic [IDX_W-1:0] i_start_idx,
  input  logic [7:0]       i_len,
  input  logic [1:0]       i_burst,
  input  logic             i_advance,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_cnt;
  logic [7:0]       r_len;
  logic [1:0]       r_burst;
  logic [IDX_W-1:0] w_next_idx;

  // INCR wraps naturally modulo the array depth
  always_comb begin
    w_next_idx = (r_burst == BURST_FIXED) ? r_idx : r_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_burst <= '0;
    end else if (i_load) begin
      r_idx   <= i_start_idx;
      r_cnt   <= '0;
      r_len   <= i_len;
      r_burst <= i_burst;
    end else if (i_advance) begin
      r_idx   <= w_next_idx;
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_cnt == r_len);

endmodule

// File: rtl/cva6_axi_mem_responder.sv
// AXI4 subordinate backed by a flop-array scratchpad; independent read and write channels,
// one outstanding burst per direction.
module cva6_axi_mem_responder
  import cva6_axi_mem_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH    = 64,
  parameter int unsigned AXI_ID_WIDTH      = 4,
  parameter logic [63:0] MEM_BASE          = 64'h8000_0000,
  parameter int unsigned MEM_WORDS         = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          axi_req_i_aw_valid,
  output logic                          axi_resp_o_aw_ready,
  input  logic [AXI_ID_WIDTH-1:0]       axi_req_i_aw_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  axi_req_i_aw_bits_addr,
  input  logic [7:0]                    axi_req_i_aw_bits_len,
  input  logic [1:0]                    axi_req_i_aw_bits_burst,
  input  logic                          axi_req_i_w_valid,
  output logic                          axi_resp_o_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_req_i_w_bits_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_req_i_w_bits_strb,
  input  logic                          axi_req_i_w_bits_last,
  output logic                          axi_resp_o_b_valid,
  input  logic                          axi_req_i_b_ready,
  output logic [AXI_ID_WIDTH-1:0]       axi_resp_o_b_bits_id,
  output logic [1:0]                    axi_resp_o_b_bits_resp,
  input  logic                          axi_req_i_ar_valid,
  output logic                          axi_resp_o_ar_ready,
  input  logic [AXI_ID_WIDTH-1:0]       axi_req_i_ar_bits_id,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  axi_req_i_ar_bits_addr,
  input  logic [7:0]                    axi_req_i_ar_bits_len,
  input  logic [1:0]                    axi_req_i_ar_bits_burst,
  output logic                          axi_resp_o_r_valid,
  input  logic                          axi_req_i_r_ready,
  output logic [AXI_ID_WIDTH-1:0]       axi_resp_o_r_bits_id,
  output logic [AXI_DATA_WIDTH-1:0]     axi_resp_o_r_bits_data,
  output logic [1:0]                    axi_resp_o_r_bits_resp,
  output logic                          axi_resp_o_r_bits_last
);

  localparam int unsigned AW     = AXI_ADDRESS_WIDTH;
  localparam int unsigned NB     = AXI_DATA_WIDTH / 8;
  localparam int unsigned NB_LOG = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] BASE_A = MEM_BASE[AW-1:0];

  function automatic logic [1:0] req_resp(input logic [AW-1:0] addr,
                                          input logic [7:0]    len,
                                          input logic [1:0]    burst);
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    first = (addr - BASE_A) >> NB_LOG;
    last  = (burst == BURST_INCR) ? first + AW'(len) : first;
    if (addr < BASE_A || first >= AW'(MEM_WORDS) || last >= AW'(MEM_WORDS))
      return RESP_DECERR;
    if (burst == BURST_WRAP || burst == BURST_RSVD)
      return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  // ---------------- write channel ----------------
  w_state_e                r_w_state, w_w_state_d;
  logic                    w_aw_ready, w_w_ready, w_b_valid;
  logic                    w_aw_hs, w_w_hs;
  logic [1:0]              w_aw_resp;
  logic [IDX_W-1:0]        w_aw_idx, w_wc_idx;
  logic                    w_wc_last;
  logic [AXI_ID_WIDTH-1:0] r_w_id;
  logic [1:0]              r_w_resp;
  logic                    r_w_drop;

  assign w_aw_resp = req_resp(axi_req_i_aw_bits_addr, axi_req_i_aw_bits_len,
                              axi_req_i_aw_bits_burst);
  assign w_aw_idx  = IDX_W'((axi_req_i_aw_bits_addr - BASE_A) >> NB_LOG);
  assign w_aw_hs   = axi_req_i_aw_valid && w_aw_ready;
  assign w_w_hs    = axi_req_i_w_valid && w_w_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_w_state <= W_IDLE;
    else         r_w_state <= w_w_state_d;
  end

  always_comb begin
    w_w_state_d = r_w_state;
    w_aw_ready  = 1'b0;
    w_w_ready   = 1'b0;
    w_b_valid   = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        w_aw_ready = rst_ni;
        if (axi_req_i_aw_valid && rst_ni) w_w_state_d = W_DATA;
      end
      W_DATA: begin
        w_w_ready = 1'b1;
        if (axi_req_i_w_valid && w_wc_last) w_w_state_d = W_RESP;
      end
      W_RESP: begin
        w_b_valid = 1'b1;
        if (axi_req_i_b_ready) w_w_state_d = W_IDLE;
      end
      default: w_w_state_d = W_IDLE;
    endcase
  end

  cva6_axi_mem_beat_ctr #(.IDX_W(IDX_W)) u_wr_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_load      (w_aw_hs),
    .i_start_idx (w_aw_idx),
    .i_len       (axi_req_i_aw_bits_len),
    .i_burst     (axi_req_i_aw_bits_burst),
    .i_advance   (w_w_hs),
    .o_idx       (w_wc_idx),
    .o_last      (w_wc_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_w_id   <= '0;
      r_w_resp <= '0;
      r_w_drop <= 1'b0;
    end else if (w_aw_hs) begin
      r_w_id   <= axi_req_i_aw_bits_id;
      r_w_resp <= w_aw_resp;
      r_w_drop <= (w_aw_resp != RESP_OKAY);
    end else if (w_w_hs && (axi_req_i_w_bits_last != w_wc_last) && r_w_resp == RESP_OKAY) begin
      r_w_resp <= RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_hs && !r_w_drop) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (axi_req_i_w_bits_strb[b])
          r_mem[w_wc_idx][b*8 +: 8] <= axi_req_i_w_bits_data[b*8 +: 8];
      end
    end
  end

  assign axi_resp_o_aw_ready    = w_aw_ready;
  assign axi_resp_o_w_ready     = w_w_ready;
  assign axi_resp_o_b_valid     = w_b_valid;
  assign axi_resp_o_b_bits_id   = r_w_id;
  assign axi_resp_o_b_bits_resp = r_w_resp;

  // ---------------- read channel ----------------
  r_state_e                  r_r_state, w_r_state_d;
  logic                      w_ar_ready, w_r_valid, w_r_last;
  logic                      w_ar_hs, w_r_hs;
  logic [1:0]                w_ar_resp;
  logic [IDX_W-1:0]          w_ar_idx, w_ar_load_idx, w_rc_idx, w_rd_idx;
  logic                      w_rc_last;
  logic [AXI_DATA_WIDTH-1:0] w_rd_data;
  logic [AXI_ID_WIDTH-1:0]   r_r_id;
  logic [1:0]                r_r_resp;
  logic [AXI_DATA_WIDTH-1:0] r_r_data;

  assign w_ar_resp = req_resp(axi_req_i_ar_bits_addr, axi_req_i_ar_bits_len,
                              axi_req_i_ar_bits_burst);
  assign w_ar_idx  = IDX_W'((axi_req_i_ar_bits_addr - BASE_A) >> NB_LOG);
  assign w_ar_hs   = axi_req_i_ar_valid && w_ar_ready;
  assign w_r_hs    = w_r_valid && axi_req_i_r_ready;

  // Beat 0 is fetched at AR time, so the counter is preloaded one beat ahead
  // and always holds the index of the next word to fetch.
  assign w_ar_load_idx = (axi_req_i_ar_bits_burst == BURST_INCR) ? w_ar_idx + IDX_W'(1) : w_ar_idx;
  assign w_rd_idx      = (r_r_state == R_IDLE) ? w_ar_idx : w_rc_idx;
  assign w_rd_data     = r_mem[w_rd_idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_r_state <= R_IDLE;
    else         r_r_state <= w_r_state_d;
  end

  always_comb begin
    w_r_state_d = r_r_state;
    w_ar_ready  = 1'b0;
    w_r_valid   = 1'b0;
    w_r_last    = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        w_ar_ready = rst_ni;
        if (axi_req_i_ar_valid && rst_ni) w_r_state_d = R_DATA;
      end
      R_DATA: begin
        w_r_valid = 1'b1;
        w_r_last  = w_rc_last;
        if (axi_req_i_r_ready && w_rc_last) w_r_state_d = R_IDLE;
      end
      default: w_r_state_d = R_IDLE;
    endcase
  end

  cva6_axi_mem_beat_ctr #(.IDX_W(IDX_W)) u_rd_ctr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_load      (w_ar_hs),
    .i_start_idx (w_ar_load_idx),
    .i_len       (axi_req_i_ar_bits_len),
    .i_burst     (axi_req_i_ar_bits_burst),
    .i_advance   (w_r_hs),
    .o_idx       (w_rc_idx),
    .o_last      (w_rc_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_r_id   <= '0;
      r_r_resp <= '0;
      r_r_data <= '0;
    end else if (w_ar_hs) begin
      r_r_id   <= axi_req_i_ar_bits_id;
      r_r_resp <= w_ar_resp;
      r_r_data <= (w_ar_resp == RESP_OKAY) ? w_rd_data : '0;
    end else if (w_r_hs && !w_rc_last) begin
      r_r_data <= (r_r_resp == RESP_OKAY) ? w_rd_data : '0;
    end
  end

  assign axi_resp_o_ar_ready    = w_ar_ready;
  assign axi_resp_o_r_valid     = w_r_valid;
  assign axi_resp_o_r_bits_id   = r_r_id;
  assign axi_resp_o_r_bits_data = r_r_data;
  assign axi_resp_o_r_bits_resp = r_r_resp;
  assign axi_resp_o_r_bits_last = w_r_last;

endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
// Directed self-checking bench for the AXI scratchpad responder.
module tb_cva6_axi_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          LIMIT = 64;

  logic        clk, rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [3:0]  aw_id, b_id, ar_id, r_id;
  logic [63:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  int          rd_n;
  logic [3:0]  bs_id;
  logic [1:0]  bs_resp;

  cva6_axi_mem_responder #(
    .AXI_ADDRESS_WIDTH (64),
    .AXI_DATA_WIDTH    (64),
    .AXI_ID_WIDTH      (4),
    .MEM_BASE          (64'h8000_0000),
    .MEM_WORDS         (1024)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .axi_req_i_aw_valid     (aw_valid),
    .axi_resp_o_aw_ready    (aw_ready),
    .axi_req_i_aw_bits_id   (aw_id),
    .axi_req_i_aw_bits_addr (aw_addr),
    .axi_req_i_aw_bits_len  (aw_len),
    .axi_req_i_aw_bits_burst(aw_burst),
    .axi_req_i_w_valid      (w_valid),
    .axi_resp_o_w_ready     (w_ready),
    .axi_req_i_w_bits_data  (w_data),
    .axi_req_i_w_bits_strb  (w_strb),
    .axi_req_i_w_bits_last  (w_last),
    .axi_resp_o_b_valid     (b_valid),
    .axi_req_i_b_ready      (b_ready),
    .axi_resp_o_b_bits_id   (b_id),
    .axi_resp_o_b_bits_resp (b_resp),
    .axi_req_i_ar_valid     (ar_valid),
    .axi_resp_o_ar_ready    (ar_ready),
    .axi_req_i_ar_bits_id   (ar_id),
    .axi_req_i_ar_bits_addr (ar_addr),
    .axi_req_i_ar_bits_len  (ar_len),
    .axi_req_i_ar_bits_burst(ar_burst),
    .axi_resp_o_r_valid     (r_valid),
    .axi_req_i_r_ready      (r_ready),
    .axi_resp_o_r_bits_id   (r_id),
    .axi_resp_o_r_bits_data (r_data),
    .axi_resp_o_r_bits_resp (r_resp),
    .axi_resp_o_r_bits_last (r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input int len,
                       input logic [1:0] burst);
    int g = 0;
    aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_valid = 1'b1;
    while (!aw_ready && g < LIMIT) begin tick(); g++; end
    if (!aw_ready) begin
      n_checks++;
      $display("FAIL aw_handshake: aw_ready=%b, required 1 within %0d cycles", aw_ready, LIMIT);
    end
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int g = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    while (!w_ready && g < LIMIT) begin tick(); g++; end
    if (!w_ready) begin
      n_checks++;
      $display("FAIL w_handshake: w_ready=%b, required 1 within %0d cycles", w_ready, LIMIT);
    end
    tick();
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                             input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb);
    do_aw(id, addr, len, burst);
    for (int i = 0; i <= len; i++) send_w(d0 + 64'(i), strb, i == len);
    w_valid = 1'b0;
  endtask

  task automatic wait_b();
    int g = 0;
    b_ready = 1'b1;
    while (!b_valid && g < LIMIT) begin tick(); g++; end
    if (!b_valid) begin
      n_checks++;
      $display("FAIL b_handshake: b_valid=%b, required 1 within %0d cycles", b_valid, LIMIT);
    end
    bs_id = b_id; bs_resp = b_resp;
    tick();
    b_ready = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input int len,
                       input logic [1:0] burst);
    int g = 0;
    ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_valid = 1'b1;
    while (!ar_ready && g < LIMIT) begin tick(); g++; end
    if (!ar_ready) begin
      n_checks++;
      $display("FAIL ar_handshake: ar_ready=%b, required 1 within %0d cycles", ar_ready, LIMIT);
    end
    tick();
    ar_valid = 1'b0;
  endtask

  task automatic collect_r(input int n);
    int k = 0;
    rd_n = 0;
    r_ready = 1'b1;
    while (rd_n < n && k < LIMIT) begin
      if (r_valid) begin
        rd_data[rd_n] = r_data; rd_resp[rd_n] = r_resp;
        rd_last[rd_n] = r_last; rd_id[rd_n]   = r_id;
        rd_n++;
      end
      tick(); k++;
    end
    r_ready = 1'b0;
    if (rd_n != n) begin
      n_checks++;
      $display("FAIL r_beats: got %0d beats, required %0d", rd_n, n);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid} !== 5'b0)
      $display("FAIL reset_handshakes: got %b, required 00000", {aw_ready, w_ready, b_valid, ar_ready, r_valid});
    else n_pass++;
    n_checks++;
    if ({r_data, r_id, r_resp, r_last, b_id, b_resp} !== 77'b0)
      $display("FAIL reset_payload: got data=%h id=%h resp=%b last=%b bid=%h bresp=%b, required all 0",
               r_data, r_id, r_resp, r_last, b_id, b_resp);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000)
      $display("FAIL idle_after_reset: got %b, required 11000", {aw_ready, ar_ready, w_ready, b_valid, r_valid});
    else n_pass++;
  endtask

  task automatic test_incr_burst();
    write_burst(4'h5, BASE, 3, 2'b01, 64'd1, 8'hFF);
    wait_b();
    n_checks++;
    if ({bs_id, bs_resp} !== {4'h5, 2'b00})
      $display("FAIL incr_b: got id=%h resp=%b, required id=5 resp=00", bs_id, bs_resp);
    else n_pass++;
    do_ar(4'h3, BASE, 3, 2'b01);
    n_checks++;
    if (r_valid !== 1'b1) $display("FAIL r_latency: r_valid=%b one cycle after AR, required 1", r_valid);
    else n_pass++;
    collect_r(4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'(i + 1) || rd_last[i] !== (i == 3))
        $display("FAIL incr_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, rd_data[i], rd_last[i], 64'(i + 1), (i == 3));
      else n_pass++;
      n_checks++;
      if ({rd_id[i], rd_resp[i]} !== {4'h3, 2'b00})
        $display("FAIL incr_id%0d: got id=%h resp=%b, required id=3 resp=00", i, rd_id[i], rd_resp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_strobe();
    write_burst(4'h1, BASE + 64'h100, 0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wait_b();
    write_burst(4'h1, BASE + 64'h100, 0, 2'b01, 64'h11, 8'h01);
    wait_b();
    do_ar(4'h2, BASE + 64'h100, 0, 2'b01);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 64'hFFFF_FFFF_FFFF_FF11 || rd_last[0] !== 1'b1)
      $display("FAIL strobe: got data=%h last=%b, required data=ffffffffffffff11 last=1", rd_data[0], rd_last[0]);
    else n_pass++;
  endtask

  task automatic test_fixed();
    write_burst(4'h1, BASE + 64'h300, 2, 2'b00, 64'h50, 8'hFF);
    wait_b();
    do_ar(4'h2, BASE + 64'h300, 0, 2'b01);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 64'h52) $display("FAIL fixed_write: got %h, required 52", rd_data[0]);
    else n_pass++;
    do_ar(4'h2, BASE, 1, 2'b00);
    collect_r(2);
    n_checks++;
    if (rd_data[0] !== 64'd1 || rd_data[1] !== 64'd1 || rd_last[1] !== 1'b1)
      $display("FAIL fixed_read: got %h %h last=%b, required 1 1 last=1", rd_data[0], rd_data[1], rd_last[1]);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_ar(4'h7, BASE - 64'd8, 0, 2'b01);
    collect_r(1);
    n_checks++;
    if ({rd_resp[0], rd_data[0], rd_last[0], rd_id[0]} !== {2'b11, 64'd0, 1'b1, 4'h7})
      $display("FAIL decerr_below: got resp=%b data=%h last=%b id=%h, required resp=11 data=0 last=1 id=7",
               rd_resp[0], rd_data[0], rd_last[0], rd_id[0]);
    else n_pass++;
    do_ar(4'h7, BASE + 64'(1023 * 8), 1, 2'b01);
    collect_r(2);
    n_checks++;
    if ({rd_resp[0], rd_resp[1], rd_last[0], rd_last[1], rd_data[1]} !== {2'b11, 2'b11, 1'b0, 1'b1, 64'd0})
      $display("FAIL decerr_end: got resp=%b,%b last=%b,%b data=%h, required resp=11,11 last=0,1 data=0",
               rd_resp[0], rd_resp[1], rd_last[0], rd_last[1], rd_data[1]);
    else n_pass++;
    write_burst(4'h9, BASE, 1, 2'b10, 64'hDEAD_0000, 8'hFF);
    wait_b();
    n_checks++;
    if ({bs_id, bs_resp} !== {4'h9, 2'b10})
      $display("FAIL wrap_b: got id=%h resp=%b, required id=9 resp=10", bs_id, bs_resp);
    else n_pass++;
    do_ar(4'h4, BASE, 1, 2'b01);
    collect_r(2);
    n_checks++;
    if (rd_data[0] !== 64'd1 || rd_data[1] !== 64'd2)
      $display("FAIL wrap_dropped: got %h %h, required 1 2", rd_data[0], rd_data[1]);
    else n_pass++;
    do_aw(4'h6, BASE + 64'(40 * 8), 1, 2'b01);
    send_w(64'hAA, 8'hFF, 1'b1);
    send_w(64'hBB, 8'hFF, 1'b1);
    w_valid = 1'b0;
    n_checks++;
    if ({w_ready, b_valid} !== 2'b01)
      $display("FAIL last_mismatch_beats: got w_ready=%b b_valid=%b, required 0 1", w_ready, b_valid);
    else n_pass++;
    wait_b();
    n_checks++;
    if (bs_resp !== 2'b10) $display("FAIL last_mismatch_b: got resp=%b, required 10", bs_resp);
    else n_pass++;
  endtask

  task automatic test_read_stall();
    int k = 0, bad_stable = 0, bad_ar = 0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [63:0] prev_data = '0;
    logic [7:0] last_mask = '0;
    write_burst(4'h2, BASE + 64'h200, 7, 2'b01, 64'hA0, 8'hFF);
    wait_b();
    do_ar(4'h8, BASE + 64'h200, 7, 2'b01);
    rd_n = 0;
    while (rd_n < 8 && k < LIMIT) begin
      r_ready = k[0];
      if (prev_stall && (r_valid !== 1'b1 || r_data !== prev_data || r_last !== prev_last)) bad_stable++;
      if (ar_ready !== 1'b0) bad_ar++;
      if (r_valid && r_ready) begin
        rd_data[rd_n] = r_data;
        last_mask[rd_n] = r_last;
        rd_n++;
        prev_stall = 1'b0;
      end else if (r_valid) begin
        prev_stall = 1'b1; prev_data = r_data; prev_last = r_last;
      end
      tick(); k++;
    end
    r_ready = 1'b0;
    n_checks++;
    if (rd_n != 8) $display("FAIL stall_beats: got %0d beats, required 8", rd_n);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'h0A0 + 64'(i))
        $display("FAIL stall_data%0d: got %h, required %h", i, rd_data[i], 64'h0A0 + 64'(i));
      else n_pass++;
    end
    n_checks++;
    if (last_mask !== 8'h80) $display("FAIL stall_last: got mask %b, required 10000000", last_mask);
    else n_pass++;
    n_checks++;
    if (bad_stable != 0) $display("FAIL stall_stable: got %0d unstable cycles, required 0", bad_stable);
    else n_pass++;
    n_checks++;
    if (bad_ar != 0) $display("FAIL stall_ar_ready: got %0d cycles with ar_ready=1, required 0", bad_ar);
    else n_pass++;
    n_checks++;
    if (ar_ready !== 1'b1) $display("FAIL stall_ar_release: got ar_ready=%b, required 1", ar_ready);
    else n_pass++;
  endtask

  task automatic test_concurrent();
    int bad_b = 0;
    fork
      begin
        write_burst(4'hC, BASE + 64'h400, 3, 2'b01, 64'hC0, 8'hFF);
        for (int i = 0; i < 5; i++) begin
          if (b_valid !== 1'b1 || aw_ready !== 1'b0) bad_b++;
          tick();
        end
      end
      begin
        do_ar(4'h1, BASE, 3, 2'b01);
        collect_r(4);
      end
    join
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'(i + 1) || rd_last[i] !== (i == 3))
        $display("FAIL conc_beat%0d: got data=%h last=%b, required data=%h last=%b",
                 i, rd_data[i], rd_last[i], 64'(i + 1), (i == 3));
      else n_pass++;
    end
    n_checks++;
    if (bad_b != 0) $display("FAIL conc_b_hold: got %0d bad cycles, required 0", bad_b);
    else n_pass++;
    wait_b();
    n_checks++;
    if ({bs_id, bs_resp, aw_ready} !== {4'hC, 2'b00, 1'b1})
      $display("FAIL conc_b: got id=%h resp=%b aw_ready=%b, required id=c resp=00 aw_ready=1", bs_id, bs_resp, aw_ready);
    else n_pass++;
    do_ar(4'h1, BASE + 64'h408, 0, 2'b01);
    collect_r(1);
    n_checks++;
    if (rd_data[0] !== 64'hC1) $display("FAIL conc_write_data: got %h, required c1", rd_data[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int bad_b = 0;
    do_aw(4'h4, BASE + 64'h640, 3, 2'b01);
    send_w(64'h100, 8'hFF, 1'b0);
    send_w(64'h101, 8'hFF, 1'b0);
    w_data = 64'h102; w_last = 1'b0; w_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid} !== 5'b0)
      $display("FAIL midrst_async: got %b, required 00000", {aw_ready, w_ready, b_valid, ar_ready, r_valid});
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    w_valid = 1'b0;
    tick();
    b_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b_valid !== 1'b0) bad_b++;
      tick();
    end
    b_ready = 1'b0;
    n_checks++;
    if (bad_b != 0 || aw_ready !== 1'b1)
      $display("FAIL midrst_no_b: got %0d b_valid cycles aw_ready=%b, required 0 and 1", bad_b, aw_ready);
    else n_pass++;
    do_ar(4'h5, BASE + 64'h640, 1, 2'b01);
    collect_r(2);
    n_checks++;
    if (rd_data[0] !== 64'h100 || rd_data[1] !== 64'h101)
      $display("FAIL midrst_persist: got %h %h, required 100 101", rd_data[0], rd_data[1]);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    aw_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_burst = '0;
    w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; b_ready = 1'b0;
    ar_valid = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_burst = '0; r_ready = 1'b0;
    test_reset();
    test_incr_burst();
    test_strobe();
    test_fixed();
    test_errors();
    test_read_stall();
    test_concurrent();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
